// File: rtl/cnt_pkg.sv
// cnt_pkg: shared constants and helpers for the up/down modulo counter family.
// Rev 1.0
`default_nettype none

package cnt_pkg;

  localparam logic DIR_DN    = 1'b0;
  localparam logic DIR_UP    = 1'b1;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Width of a counter holding 0..n-1, never less than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cnt_presc.sv
// cnt_presc: enable prescaler, one tick every PRESC enabled cycles.
// Rev 1.0
`default_nettype none

module cnt_presc
  import cnt_pkg::*;
#(
  parameter int PRESC = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sync_clr,
  output logic tick
);

  generate
    if (PRESC == 1) begin : g_pass
      logic unused_presc;
      assign unused_presc = ^{clk, rst, sync_clr};
      assign tick = en;
    end else begin : g_div
      localparam int            PW   = clog2(PRESC);
      localparam logic [PW-1:0] LAST = PW'(PRESC - 1);

      logic [PW-1:0] pre_q;
      logic [PW-1:0] pre_d;

      always_comb begin
        pre_d = pre_q;
        if (sync_clr) begin
          pre_d = '0;
        end else if (en) begin
          pre_d = (pre_q == LAST) ? '0 : pre_q + PW'(1);
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          pre_q <= '0;
        end else begin
          pre_q <= pre_d;
        end
      end

      assign tick = en && !sync_clr && (pre_q == LAST);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/cnt_mod_updn.sv
// cnt_mod_updn: parametrised up/down counter, programmable terminal, wrap/saturate.
// Rev 1.0
`default_nettype none

module cnt_mod_updn
  import cnt_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int PRESC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic             sat,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             step;

  cnt_presc #(
    .PRESC(PRESC)
  ) u_presc (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .sync_clr(clr | load),
    .tick    (step)
  );

  // Range checks come first so no step ever depends on arithmetic rollover.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    ovf_d  = ovf_q;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (step) begin
      if (dir == DIR_UP) begin
        if (cnt_q < max_val) begin
          cnt_d = cnt_q + WIDTH'(1);
        end else if (sat == MODE_WRAP) begin
          cnt_d  = '0;
          wrap_d = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end else begin
        if (cnt_q > max_val) begin
          cnt_d = max_val;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - WIDTH'(1);
        end else if (sat == MODE_WRAP) begin
          cnt_d  = max_val;
          wrap_d = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign cnt  = cnt_q;
  assign wrap = wrap_q;
  assign ovf  = ovf_q;
  assign tc   = (dir == DIR_UP) ? (cnt_q >= max_val) : (cnt_q == '0);

endmodule

`default_nettype wire

// File: tb/tb_cnt_mod_updn.sv
// tb_cnt_mod_updn: directed scoreboard bench for cnt_mod_updn (PRESC=1 and PRESC=3).
// Rev 1.0
`default_nettype none

module tb_cnt_mod_updn;

  logic       clk = 1'b0;
  logic       rst, en, clr, load, dir, sat;
  logic [3:0] load_val, max_val;
  logic [3:0] cnt1, cnt3;
  logic       tc1, tc3, wrap1, wrap3, ovf1, ovf3;

  always #5 clk = ~clk;

  cnt_mod_updn #(.WIDTH(4), .PRESC(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .dir(dir), .sat(sat), .max_val(max_val),
    .cnt(cnt1), .tc(tc1), .wrap(wrap1), .ovf(ovf1)
  );

  cnt_mod_updn #(.WIDTH(4), .PRESC(3)) dut3 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .dir(dir), .sat(sat), .max_val(max_val),
    .cnt(cnt3), .tc(tc3), .wrap(wrap3), .ovf(ovf3)
  );

  typedef struct {
    int         sel;
    logic [3:0] cnt;
    logic       wrap;
    logic       ovf;
    logic       tc;
    string      tag;
  } exp_t;

  exp_t  q[$];
  int    checks   = 0;
  int    failures = 0;
  string tag      = "reset";

  function automatic void chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  // One clock of stimulus; the expected post-edge state goes to the scoreboard.
  task automatic cyc(input logic r, input logic e, input logic c, input logic l,
                     input logic [3:0] lv, input logic d, input logic s,
                     input logic [3:0] mx, input logic [3:0] ec,
                     input logic ew, input logic eo, input int sel);
    exp_t x;
    @(negedge clk);
    #1;
    rst = r; en = e; clr = c; load = l; load_val = lv; dir = d; sat = s; max_val = mx;
    x.sel  = sel;
    x.cnt  = ec;
    x.wrap = ew;
    x.ovf  = eo;
    x.tc   = d ? (ec >= mx) : (ec == 4'h0);
    x.tag  = tag;
    q.push_back(x);
    if (!r) begin
      #1;
      chk({tag, "/async_cnt"},  (sel == 3) ? cnt3 : cnt1, 4'h0);
      chk({tag, "/async_wrap"}, {3'b0, (sel == 3) ? wrap3 : wrap1}, 4'h0);
      chk({tag, "/async_ovf"},  {3'b0, (sel == 3) ? ovf3 : ovf1}, 4'h0);
    end
  endtask

  // Monitor: one registered result per clock, compared away from the active edge.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        if (x.sel == 3) begin
          chk({x.tag, "/cnt"},  cnt3, x.cnt);
          chk({x.tag, "/wrap"}, {3'b0, wrap3}, {3'b0, x.wrap});
          chk({x.tag, "/ovf"},  {3'b0, ovf3},  {3'b0, x.ovf});
          chk({x.tag, "/tc"},   {3'b0, tc3},   {3'b0, x.tc});
        end else begin
          chk({x.tag, "/cnt"},  cnt1, x.cnt);
          chk({x.tag, "/wrap"}, {3'b0, wrap1}, {3'b0, x.wrap});
          chk({x.tag, "/ovf"},  {3'b0, ovf1},  {3'b0, x.ovf});
          chk({x.tag, "/tc"},   {3'b0, tc1},   {3'b0, x.tc});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v;
    rst = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0;
    load_val = 4'h0; dir = 1'b1; sat = 1'b0; max_val = 4'hF;

    tag = "reset";
    cyc(0, 1, 0, 0, 4'h0, 1, 0, 4'hF, 4'h0, 0, 0, 1);

    tag = "legacy";
    for (int k = 1; k <= 17; k++)
      cyc(1, 1, 0, 0, 4'h0, 1, 0, 4'hF, 4'(k % 16), (k == 16), 0, 1);

    tag = "count_to_a";
    for (int k = 2; k <= 10; k++)
      cyc(1, 1, 0, 0, 4'h0, 1, 0, 4'hF, 4'(k), 0, 0, 1);

    tag = "en_gap";
    for (int k = 0; k < 5; k++)
      cyc(1, 0, 0, 0, 4'h0, 1, 0, 4'hF, 4'hA, 0, 0, 1);

    tag = "count_to_7";
    for (int k = 1; k <= 13; k++) begin
      v = (10 + k) % 16;
      cyc(1, 1, 0, 0, 4'h0, 1, 0, 4'hF, 4'(v), (v == 0), 0, 1);
    end

    tag = "async_rst";
    for (int k = 0; k < 5; k++)
      cyc(0, 1, 0, 0, 4'h0, 1, 0, 4'hF, 4'h0, 0, 0, 1);

    tag = "restart";
    for (int k = 1; k <= 3; k++)
      cyc(1, 1, 0, 0, 4'h0, 1, 0, 4'hF, 4'(k), 0, 0, 1);

    tag = "down_load";
    cyc(1, 0, 0, 1, 4'h2, 0, 0, 4'h5, 4'h2, 0, 0, 1);
    tag = "down_wrap";
    cyc(1, 1, 0, 0, 4'h0, 0, 0, 4'h5, 4'h1, 0, 0, 1);
    cyc(1, 1, 0, 0, 4'h0, 0, 0, 4'h5, 4'h0, 0, 0, 1);
    cyc(1, 1, 0, 0, 4'h0, 0, 0, 4'h5, 4'h5, 1, 0, 1);
    cyc(1, 1, 0, 0, 4'h0, 0, 0, 4'h5, 4'h4, 0, 0, 1);

    tag = "sat_load";
    cyc(1, 0, 0, 1, 4'h8, 1, 1, 4'h9, 4'h8, 0, 0, 1);
    tag = "sat";
    cyc(1, 1, 0, 0, 4'h0, 1, 1, 4'h9, 4'h9, 0, 0, 1);
    for (int k = 0; k < 3; k++)
      cyc(1, 1, 0, 0, 4'h0, 1, 1, 4'h9, 4'h9, 0, 1, 1);
    tag = "ovf_sticky_load";
    cyc(1, 0, 0, 1, 4'h4, 1, 1, 4'h9, 4'h4, 0, 1, 1);
    tag = "clr";
    cyc(1, 1, 1, 0, 4'h0, 1, 1, 4'h9, 4'h0, 0, 0, 1);

    tag = "max0_wrap";
    for (int k = 0; k < 3; k++)
      cyc(1, 1, 0, 0, 4'h0, 1, 0, 4'h0, 4'h0, 1, 0, 1);
    tag = "max0_sat";
    cyc(1, 1, 0, 0, 4'h0, 1, 1, 4'h0, 4'h0, 0, 1, 1);

    tag = "clr_vs_load";
    cyc(1, 1, 1, 1, 4'hC, 1, 0, 4'h7, 4'h0, 0, 0, 1);
    tag = "oor_load";
    cyc(1, 0, 0, 1, 4'hC, 0, 0, 4'h7, 4'hC, 0, 0, 1);
    tag = "oor_down";
    cyc(1, 1, 0, 0, 4'h0, 0, 0, 4'h7, 4'h7, 0, 0, 1);
    tag = "oor_load_up";
    cyc(1, 0, 0, 1, 4'hC, 1, 0, 4'h7, 4'hC, 0, 0, 1);
    tag = "oor_up";
    cyc(1, 1, 0, 0, 4'h0, 1, 0, 4'h7, 4'h0, 1, 0, 1);

    tag = "presc_clr";
    cyc(1, 0, 1, 0, 4'h0, 1, 0, 4'hF, 4'h0, 0, 0, 3);
    tag = "presc_run";
    for (int k = 1; k <= 9; k++)
      cyc(1, 1, 0, 0, 4'h0, 1, 0, 4'hF, 4'(k / 3), 0, 0, 3);
    tag = "presc_clr_load";
    cyc(1, 1, 1, 1, 4'h5, 1, 0, 4'hF, 4'h0, 0, 0, 3);
    tag = "presc_mid";
    cyc(1, 1, 0, 0, 4'h0, 1, 0, 4'hF, 4'h0, 0, 0, 3);
    cyc(1, 1, 0, 0, 4'h0, 1, 0, 4'hF, 4'h0, 0, 0, 3);
    cyc(1, 1, 0, 1, 4'h5, 1, 0, 4'hF, 4'h5, 0, 0, 3);
    cyc(1, 1, 0, 0, 4'h0, 1, 0, 4'hF, 4'h5, 0, 0, 3);
    cyc(1, 0, 0, 0, 4'h0, 1, 0, 4'hF, 4'h5, 0, 0, 3);
    cyc(1, 1, 0, 0, 4'h0, 1, 0, 4'hF, 4'h5, 0, 0, 3);
    cyc(1, 1, 0, 0, 4'h0, 1, 0, 4'hF, 4'h6, 0, 0, 3);

    @(negedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cnt_mod_updn.md
Name: cnt_mod_updn

Overview:
- Parametrised successor to the fixed 4-bit 0..F enable counter.
- Generalised in width; adds runtime-programmable terminal value, up/down counting, synchronous load and clear, and wrap or saturate mode.
- Adds an enable prescaler plus terminal-count, wrap and sticky-overflow flags.
- Used as the general event/timer counter in the fundamental-hardware library.
- With WIDTH=4, PRESC=1, max_val=4'hF, dir=1, sat=0 it behaves exactly as the 0..F counter.

Parameters:
- WIDTH, 4, counter width in bits (>=1).
- PRESC, 1, number of enabled cycles per count step (>=1); 1 = step on every enabled cycle.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  count enable; also advances the prescaler.
- clr  input  1  synchronous clear.
- load  input  1  synchronous load.
- load_val  input  WIDTH  value taken on load.
- dir  input  1  1 = count up, 0 = count down.
- sat  input  1  0 = wrap mode, 1 = saturate mode.
- max_val  input  WIDTH  terminal value; count range is 0..max_val.
- cnt  output  WIDTH  current count, registered.
- tc  output  1  terminal count, combinational from cnt/dir/max_val.
- wrap  output  1  one-cycle registered pulse on wrap.
- ovf  output  1  sticky saturation-attempt flag.

Behaviour:
- Reset (rst=0, async): cnt=0, wrap=0, ovf=0, prescaler count pre=0. Holds while rst=0. Counting resumes on the first rising edge after rst goes high.
- Per-edge priority: clr > load > step > hold.
- clr=1: cnt=0, pre=0, wrap=0, ovf=0.
- load=1 (clr=0): cnt=load_val, pre=0, wrap=0. ovf unchanged. load_val > max_val is stored unclipped.
- Prescaler: when en=1 and no clr/load:
  - pre==PRESC-1 → pre=0 and step=1.
  - otherwise pre++ and step=0.
  - en=0 holds pre.
  - PRESC=1 gives step=en.
- Up step (dir=1):
  - cnt<max_val → cnt+1.
  - cnt>=max_val, sat=0 → cnt=0, wrap=1 for the next cycle.
  - cnt>=max_val, sat=1 → cnt held, ovf=1.
- Down step (dir=0):
  - cnt>max_val → cnt=max_val.
  - 0<cnt<=max_val → cnt-1.
  - cnt==0, sat=0 → cnt=max_val, wrap=1.
  - cnt==0, sat=1 → cnt held at 0, ovf=1.
- wrap is high for exactly the cycle following the wrapping edge, concurrent with the new cnt. Otherwise 0.
- ovf stays set until clr or reset.
- tc = dir ? (cnt>=max_val) : (cnt==0). Combinational, no latency.
- Latency: step on enabled edge N → cnt updated after edge N. Zero extra pipeline.
- max_val=0:
  - cnt stays 0 (after any load > 0, the first step returns to 0 in wrap mode).
  - Wrap mode: every step pulses wrap.
  - Saturate mode: every step sets ovf.
- Changing dir, sat or max_val mid-count takes effect on the next step. No state is discarded.
- Arithmetic is modulo 2^WIDTH internally, but the comparisons above guarantee no natural overflow. Implementation must not rely on wrap-through-2^WIDTH.

Decomposition:
- Package cnt_pkg: constants DIR_DN=1'b0, DIR_UP=1'b1, MODE_WRAP=1'b0, MODE_SAT=1'b1; function clog2 for prescaler width (max(1, clog2(PRESC))).
- Sub-module cnt_presc:
  - Parameter PRESC.
  - Ports clk, rst, en, sync_clr, tick.
  - sync_clr driven by clr|load.
  - PRESC=1 generates a pass-through tick=en (no flops).

Test Plan:
- Legacy: WIDTH=4, PRESC=1, max_val=F, dir=1, sat=0. rst low 1 cycle, en=1 for 18 cycles → cnt 0,1..F,0,1. wrap high only in the cycle cnt=0 after F. tc high when cnt=F.
- Enable/reset gaps: en=0 for 5 cycles mid-count at cnt=A → cnt holds A. rst low for 5 cycles at cnt=7 → cnt=0 immediately (asynchronously, before the next edge). Count restarts after release.
- Down wrap with programmable max: max_val=5, dir=0, load_val=2 then en=1 → 2,1,0,5,4. wrap pulses after 0→5. tc high at cnt=0.
- Saturate: sat=1, max_val=9, load 8, dir=1, en=1 for 4 cycles → 9,9,9,9. ovf=1 from the first hold onward, wrap never set. clr → cnt=0, ovf=0.
- Prescaler/priority: PRESC=3, en=1 continuous → cnt increments every 3rd cycle. load=1 and clr=1 in the same cycle → cnt=0 (clr wins). Load mid-prescale → next step exactly 3 enabled cycles later.
- Out-of-range/edges: max_val=0 wrap mode, en=1 → cnt stays 0, wrap high every step. load_val=C with max_val=7: dir=0 → next cnt=7; dir=1, sat=0 → next cnt=0 with wrap.
